// File: rtl/gencon.sv
// gencon: controller/datapath for a signed keypad calculator.
// It collects two decimal operands and a one-hot operator. It then computes add,
// subtract or a sequential shift-add multiply, wrapped to WIDTH bits. The result
// is held on the display until the next key or operator arrives.
module gencon #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic             complete,
    output logic [WIDTH-1:0] display_output
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int         CNT_W  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] TEN  = WIDTH'(10);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    // Apply one key code to the operand being entered. Digits shift in decimally,
    // code A negates, and every other code leaves the operand unchanged.
    function automatic logic [WIDTH-1:0] key_apply(input logic [WIDTH-1:0] cur,
                                                   input logic [3:0]       code);
        logic [WIDTH-1:0] digit;
        digit = {{(WIDTH-4){1'b0}}, code};
        if (code <= 4'd9) begin
            key_apply = cur * TEN + digit;
        end else if (code == 4'hA) begin
            key_apply = ZERO - cur;
        end else begin
            key_apply = cur;
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic [WIDTH-1:0] res_r, res_nxt_s;
    logic [2:0]       op_r, op_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] disp_r, disp_nxt_s;
    logic             comp_r, comp_nxt_s;
    logic             read_prev_r;
    logic             key_edge_s;
    logic             is_digit_s;
    logic             op_valid_s;
    logic [CNT_W-1:0] last_cnt_s;

    assign key_edge_s = read_input & ~read_prev_r;
    assign is_digit_s = (keypad_input <= 4'd9);
    assign op_valid_s = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
                        (operator_input == OP_MUL);
    // Add/sub use one compute step. Multiply uses one step per operand bit.
    // The finish step follows the last compute step.
    assign last_cnt_s = (op_r == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(1);

    assign complete       = comp_r;
    assign display_output = disp_r;

    // State, datapath and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (nRST) begin
            state_r     <= ENTER_A;
            a_r         <= ZERO;
            b_r         <= ZERO;
            res_r       <= ZERO;
            op_r        <= 3'b000;
            cnt_r       <= {CNT_W{1'b0}};
            disp_r      <= ZERO;
            comp_r      <= 1'b0;
            read_prev_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            res_r       <= res_nxt_s;
            op_r        <= op_nxt_s;
            cnt_r       <= cnt_nxt_s;
            disp_r      <= disp_nxt_s;
            comp_r      <= comp_nxt_s;
            read_prev_r <= read_input;
        end
    end

    // Next-state and datapath decisions.
    // Equals has priority over an operator, and an operator has priority over a key.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        res_nxt_s   = res_r;
        op_nxt_s    = op_r;
        cnt_nxt_s   = cnt_r;
        disp_nxt_s  = disp_r;
        comp_nxt_s  = comp_r;
        case (state_r)
            ENTER_A: begin
                if (op_valid_s) begin
                    op_nxt_s    = operator_input;
                    b_nxt_s     = ZERO;
                    disp_nxt_s  = ZERO;
                    state_nxt_s = ENTER_B;
                end else if (key_edge_s) begin
                    a_nxt_s    = key_apply(a_r, keypad_input);
                    disp_nxt_s = key_apply(a_r, keypad_input);
                end else begin
                    a_nxt_s = a_r;
                end
            end
            ENTER_B: begin
                if (equal_input) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    res_nxt_s   = ZERO;
                    state_nxt_s = COMPUTE;
                end else if (key_edge_s) begin
                    b_nxt_s    = key_apply(b_r, keypad_input);
                    disp_nxt_s = key_apply(b_r, keypad_input);
                end else begin
                    b_nxt_s = b_r;
                end
            end
            COMPUTE: begin
                if (cnt_r == last_cnt_s) begin
                    disp_nxt_s  = res_r;
                    comp_nxt_s  = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                    case (op_r)
                        OP_ADD: res_nxt_s = a_r + b_r;
                        OP_SUB: res_nxt_s = a_r - b_r;
                        OP_MUL: begin
                            // Low WIDTH bits of the shift-add product are correct for signed operands.
                            if (b_r[0]) begin
                                res_nxt_s = res_r + a_r;
                            end else begin
                                res_nxt_s = res_r;
                            end
                            a_nxt_s = a_r << 1;
                            b_nxt_s = b_r >> 1;
                        end
                        default: res_nxt_s = res_r;
                    endcase
                end
            end
            DONE: begin
                if (op_valid_s) begin
                    a_nxt_s     = res_r;
                    op_nxt_s    = operator_input;
                    b_nxt_s     = ZERO;
                    comp_nxt_s  = 1'b0;
                    disp_nxt_s  = ZERO;
                    state_nxt_s = ENTER_B;
                end else if (key_edge_s && is_digit_s) begin
                    a_nxt_s     = {{(WIDTH-4){1'b0}}, keypad_input};
                    b_nxt_s     = ZERO;
                    comp_nxt_s  = 1'b0;
                    disp_nxt_s  = {{(WIDTH-4){1'b0}}, keypad_input};
                    state_nxt_s = ENTER_A;
                end else begin
                    comp_nxt_s = comp_r;
                end
            end
            default: begin
                state_nxt_s = ENTER_A;
            end
        endcase
    end

endmodule

// File: tb/tb_gencon.sv
// Scoreboard bench for gencon. A behavioural calculator model predicts each result
// and its latency when equals is pressed. A monitor pops the prediction when
// `complete` rises and compares it against the DUT.
module tb_gencon;

    logic        clk;
    logic        nRST;
    logic [3:0]  keypad_input;
    logic        read_input;
    logic [2:0]  operator_input;
    logic        equal_input;
    logic        complete;
    logic [15:0] display_output;

    gencon #(.WIDTH(16)) dut (
        .clk(clk),
        .nRST(nRST),
        .keypad_input(keypad_input),
        .read_input(read_input),
        .operator_input(operator_input),
        .equal_input(equal_input),
        .complete(complete),
        .display_output(display_output)
    );

    typedef struct {
        int val;
        int edge_n;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   comp_prev = 0;

    // Calculator model: phase 0 = entering a, 1 = entering b, 3 = result shown
    int mstate = 0;
    int ma = 0;
    int mb = 0;
    int mres = 0;
    int mop = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mdisp();
        if (mstate == 0) return ma;
        else if (mstate == 1) return mb;
        else return mres;
    endfunction

    task automatic model_key(input int c);
        if (mstate == 0 || mstate == 1) begin
            int cur;
            cur = (mstate == 0) ? ma : mb;
            if (c <= 9) cur = (cur * 10 + c) & 32'hFFFF;
            else if (c == 10) cur = (-cur) & 32'hFFFF;
            if (mstate == 0) ma = cur;
            else mb = cur;
        end else if (mstate == 3 && c <= 9) begin
            ma = c;
            mb = 0;
            mstate = 0;
        end
    endtask

    task automatic model_op(input int o);
        if (o == 1 || o == 2 || o == 4) begin
            if (mstate == 0) begin
                mop = o; mb = 0; mstate = 1;
            end else if (mstate == 3) begin
                ma = mres; mop = o; mb = 0; mstate = 1;
            end
        end
    endtask

    task automatic model_eq(input int edge_n);
        exp_t e;
        if (mstate == 1) begin
            if (mop == 1) e.val = (ma + mb) & 32'hFFFF;
            else if (mop == 2) e.val = (ma - mb) & 32'hFFFF;
            else e.val = int'((longint'(ma) * longint'(mb)) & 64'hFFFF);
            e.lat    = (mop == 4) ? 17 : 2;
            e.edge_n = edge_n;
            sb.push_back(e);
            mres   = e.val;
            mstate = 3;
        end
    endtask

    // Monitor: on each rising `complete`, pop the oldest prediction and compare it
    always @(negedge clk) begin
        if (complete && comp_prev == 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_complete", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(display_output), e.val);
                chk("latency", cyc - e.edge_n, e.lat);
            end
        end
        comp_prev = int'(complete);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        keypad_input = c;
        read_input   = 1'b1;
        model_key(int'(c));
        tick();
        read_input = 1'b0;
        tick();
        chk("disp_key", int'(display_output), mdisp());
    endtask

    task automatic do_op(input logic [2:0] o);
        operator_input = o;
        model_op(int'(o));
        tick();
        operator_input = 3'b000;
        tick();
        chk("disp_op", int'(display_output), mdisp());
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("complete_timeout", 0, 1);
            sb.delete();
        end
        tick();
    endtask

    task automatic press_eq();
        equal_input = 1'b1;
        model_eq(cyc + 1);
        tick();
        equal_input = 1'b0;
        wait_drain();
    endtask

    task automatic keys(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) key(4'(s[i] - "0"));
    endtask

    function automatic logic [2:0] rand_op();
        case ($urandom_range(0, 2))
            0: return 3'b001;
            1: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] rand_bad_op();
        case ($urandom_range(0, 3))
            0: return 3'b011;
            1: return 3'b101;
            2: return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    initial begin
        nRST = 1'b1;
        keypad_input = 4'd0;
        read_input = 1'b0;
        operator_input = 3'b000;
        equal_input = 1'b0;
        tick();
        tick();
        chk("reset_complete", int'(complete), 0);
        chk("reset_display", int'(display_output), 0);
        nRST = 1'b0;
        tick();

        // Basic arithmetic and the worked examples
        key(4'd2); do_op(3'b001); key(4'd3); press_eq();
        chk("add_2_3", int'(display_output), 5);
        keys(1000); do_op(3'b001); keys(2345); press_eq();
        chk("add_1000_2345", int'(display_output), 3345);
        key(4'd3); do_op(3'b010); key(4'd5); press_eq();
        chk("sub_3_5", int'(display_output), 16'hFFFE);
        key(4'd3); key(4'hA); do_op(3'b010); key(4'd5); key(4'hA); press_eq();
        chk("sub_neg", int'(display_output), 2);
        key(4'd4); do_op(3'b100); key(4'd3); press_eq();
        chk("mul_4_3", int'(display_output), 12);
        keys(128); do_op(3'b100); keys(256); press_eq();
        chk("mul_wrap", int'(display_output), 16'h8000);
        key(4'd3); key(4'hA); do_op(3'b100); key(4'd6); key(4'hA); press_eq();
        chk("mul_negneg", int'(display_output), 18);
        keys(32767); do_op(3'b100); key(4'd1); press_eq();
        chk("mul_max", int'(display_output), 32767);
        keys(12); key(4'hA); do_op(3'b100); keys(3000); press_eq();
        chk("mul_neg_wrap", int'(display_output), 29536);
        keys(999); key(4'hA); do_op(3'b010); keys(999); press_eq();
        chk("sub_neg_999", int'(display_output), 63538);
        keys(32768); key(4'hA); do_op(3'b001); keys(32767); press_eq();
        chk("neg_min_add", int'(display_output), 16'hFFFF);
        keys(70000);
        chk("wrap_70000", int'(display_output), 4464);
        do_op(3'b001); key(4'd0); press_eq();
        key(4'd0); do_op(3'b100); keys(100); press_eq();
        chk("mul_zero", int'(display_output), 0);
        keys(99); do_op(3'b010); key(4'd0); press_eq();
        chk("sub_zero", int'(display_output), 99);

        // Control: equals ignored in ENTER_A, invalid operator, held strobe, chaining
        key(4'd5);
        equal_input = 1'b1; model_eq(cyc + 1); tick(); equal_input = 1'b0;
        repeat (20) tick();
        chk("eq_in_enter_a", int'(display_output), 5);
        do_op(3'b011); key(4'd2);
        chk("bad_op_ignored", int'(display_output), 52);
        keypad_input = 4'd4; read_input = 1'b1; model_key(4);
        tick(); tick(); tick();
        read_input = 1'b0; tick();
        chk("held_strobe", int'(display_output), 524);
        do_op(3'b001); do_op(3'b010); key(4'd6); press_eq();
        chk("op_in_b_ignored", int'(display_output), 530);
        do_op(3'b010); keys(30); press_eq();
        chk("chain_sub", int'(display_output), 500);
        do_op(3'b100); key(4'd2); press_eq();
        chk("chain_mul", int'(display_output), 1000);

        // Equals and a key strobe together: equals wins, the key is dropped
        key(4'd1); do_op(3'b001); key(4'd2);
        keypad_input = 4'd7; read_input = 1'b1; equal_input = 1'b1;
        model_eq(cyc + 1);
        tick();
        read_input = 1'b0; equal_input = 1'b0;
        wait_drain();
        chk("eq_beats_key", int'(display_output), 3);

        // Reset in the middle of a multiply aborts it
        key(4'd5); do_op(3'b100); key(4'd7);
        equal_input = 1'b1; tick(); equal_input = 1'b0;
        repeat (5) tick();
        nRST = 1'b1; tick(); nRST = 1'b0;
        chk("rst_mid_complete", int'(complete), 0);
        chk("rst_mid_display", int'(display_output), 0);
        mstate = 0; ma = 0; mb = 0; mres = 0; mop = 0;
        repeat (20) tick();
        key(4'd1); do_op(3'b100); key(4'd1); press_eq();
        chk("after_rst_mul", int'(display_output), 1);

        // Randomized sessions checked against the model
        for (int i = 0; i < 30; i++) begin
            if (mstate == 3 && $urandom_range(0, 2) == 0) begin
                do_op(rand_op());
            end else begin
                int na;
                key(4'($urandom_range(1, 9)));
                na = $urandom_range(0, 4);
                for (int k = 0; k < na; k++) key(4'($urandom_range(0, 9)));
                if ($urandom_range(0, 3) == 0) key(4'hA);
                if ($urandom_range(0, 5) == 0) key(4'($urandom_range(11, 15)));
                if ($urandom_range(0, 4) == 0) do_op(rand_bad_op());
                do_op(rand_op());
            end
            begin
                int nb;
                nb = $urandom_range(1, 5);
                for (int k = 0; k < nb; k++) key(4'($urandom_range(0, 9)));
                if ($urandom_range(0, 3) == 0) key(4'hA);
                if ($urandom_range(0, 5) == 0) do_op(rand_op());
            end
            press_eq();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
